pla_cube_sop_pipe: RTL and testbench
====================================

Name: pla_cube_sop_pipe

Overview:
Parametrised, programmable sum-of-products evaluator: N_CUBE cubes, each a (care, value) pair over an N_IN-bit input vector, ORed to one output.
- Successor to the fixed single-cube detectors in the benchmark netlists; any autosymmetry benchmark cube set can be loaded at run time instead of re-synthesised.
- Sits between a stimulus source and a checker/scoreboard, with a valid/ready stream on both sides and a 2-stage pipeline.

Parameters:
- N_IN, 14, input vector width (1..64).
- N_CUBE, 8, number of programmable cubes (1..64).
- IDX_W, $clog2(N_CUBE) (min 1), cube index width (derived, not overridden).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  cube table write strobe.
- cfg_idx  in  IDX_W  cube written.
- cfg_care  in  N_IN  care mask, 1 = literal present.
- cfg_val  in  N_IN  literal polarity, 1 = positive, 0 = complemented.
- cfg_en  in  1  cube enable written with the cube.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts x this cycle.
- x  in  N_IN  input vector, bit i = xi.
- out_valid  out  1  y valid.
- out_ready  in  1  downstream accepts y.
- y  out  1  SOP result.

Behaviour:
- Reset (async assert, sync-released deassert): all cube_en = 0; care/val = 0; stage valids = 0; out_valid = 0; y = 0. in_ready is 1 one cycle after reset release.
- Cube match k: cube_en[k] & ((x ^ val[k]) & care[k]) == 0. An enabled cube with care = 0 always matches.
- Stage 1 registers match_vec[N_CUBE-1:0] on input accept (in_valid & in_ready).
- Stage 2 registers y = |match_vec and drives out_valid.
- Latency: accept in cycle T gives out_valid/y in cycle T+2 when not stalled. Throughput: 1 vector/cycle.
- Stall rule: stage 2 holds while out_valid & ~out_ready. Stage 1 advances iff stage 2 is empty or draining.
- in_ready = ~s1_valid | ~(out_valid & ~out_ready). Combinational from out_ready; no skid buffer.
- y and out_valid are stable while stalled. out_valid never drops without a handshake.
- Config writes are allowed at any time:
  - Write in cycle T takes effect for vectors accepted in cycle T+1 onward.
  - Vectors already in stage 1/2 keep their computed result.
  - A write to the cube being matched in the same cycle uses the old entry.
- cfg_idx >= N_CUBE: write ignored.
- N_CUBE not a power of 2: unused index codes are inert.
- No cube enabled: y = 0 for every accepted vector.
- Reset mid-stream: in-flight vectors are dropped and the cube table is cleared. Software must reprogram.

Optional Feature:
- Macro PLA_MATCH_VEC_EN.
- Defined:
  - Extra output port match_vec (out, N_CUBE), registered in stage 2 alongside y, same valid/stall rules, reset 0.
  - Extra output first_idx (out, IDX_W): lowest matching cube index, 0 when none match.
- Undefined: neither port exists; the stage-2 register holds only y.

Decomposition:
- Package pla_cube_pkg: typedef cube_t {en, care, val} parameterised via N_IN; function cube_match(cube_t, x); constant PLA_MAX_W = 64.
- One sub-module, pla_cube_match: purely combinational N_IN-bit single-cube comparator, instantiated N_CUBE times by generate.
- Pipeline, handshake and cube table live in the top module.

Test Plan:
- Reset, no programming, 16 random vectors with out_ready=1 -> y=0 each, out_valid 2 cycles after accept.
- Program cube 0 care=14'h3FFF val=14'h3D25 en=1:
  - x=14'h3D25 -> y=1.
  - x=14'h3D27 (x1 set) -> y=0.
  - x=14'h3D24 (x0 clear) -> y=0.
- Cube 0 as above, cube 3 care=14'h0003 val=14'h0002 en=1:
  - x=14'h0002 -> y=1.
  - x=14'h0001 -> y=0.
  - With PLA_MATCH_VEC_EN, x=14'h3D25 -> match_vec=8'h01, first_idx=0.
- Stream 6 vectors with out_ready held 0 for cycles 3..7:
  - in_ready falls once both stages are full.
  - y/out_valid are stable through the stall.
  - All 6 results arrive in order with none lost or duplicated.
- Vector A accepted in cycle T alongside a cfg_we disabling cube 0 in cycle T:
  - A (x=14'h3D25) -> y=1.
  - Same x accepted in cycle T+1 -> y=0.
- Assert rst_n low with 2 vectors in flight -> out_valid=0 immediately; after release, x=14'h3D25 -> y=0 (table cleared).

Source files
------------

// File: rtl/pla_cube_pkg.sv
// pla_cube_pkg: cube record and match helper shared by the SOP evaluator.
package pla_cube_pkg;

    localparam int PLA_MAX_W = 64;

    // Fields are sized to the widest supported input; narrower users zero-extend.
    typedef struct packed {
        logic                 en;
        logic [PLA_MAX_W-1:0] care;
        logic [PLA_MAX_W-1:0] val;
    } cube_t;

    function automatic logic cube_match(input cube_t c, input logic [PLA_MAX_W-1:0] v);
        return c.en & (((v ^ c.val) & c.care) == '0);
    endfunction

endpackage

// File: rtl/pla_cube_sop_pipe_match.sv
// pla_cube_match: combinational single-cube comparator over an N_IN-bit vector.
module pla_cube_match
    import pla_cube_pkg::*;
#(
    parameter int N_IN = 14
) (
    input  logic            en,
    input  logic [N_IN-1:0] care,
    input  logic [N_IN-1:0] val,
    input  logic [N_IN-1:0] x,
    output logic            match
);

    cube_t w_cube;

    always_comb begin
        w_cube.en   = en;
        w_cube.care = PLA_MAX_W'(care);
        w_cube.val  = PLA_MAX_W'(val);
    end

    assign match = cube_match(w_cube, PLA_MAX_W'(x));

endmodule

// File: rtl/pla_cube_sop_pipe.sv
// pla_cube_sop_pipe: programmable N_CUBE-cube sum-of-products with a 2-stage valid/ready pipe.
// Defining PLA_MATCH_VEC_EN adds the stage-2 match_vec and lowest matching first_idx outputs.
module pla_cube_sop_pipe
    import pla_cube_pkg::*;
#(
    parameter int N_IN   = 14,
    parameter int N_CUBE = 8,
    localparam int IDX_W = (N_CUBE > 1) ? $clog2(N_CUBE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic              cfg_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PLA_MATCH_VEC_EN
    output logic [N_CUBE-1:0] match_vec,
    output logic [IDX_W-1:0]  first_idx,
`endif
    output logic              y
);

    logic [N_CUBE-1:0] r_en;
    logic [N_IN-1:0]   r_care [N_CUBE];
    logic [N_IN-1:0]   r_val  [N_CUBE];
    logic [N_CUBE-1:0] w_match;
    logic              r_s1_valid;
    logic [N_CUBE-1:0] r_s1_match;
    logic              r_out_valid;
    logic              r_y;
    logic              w_s2_hold;

    genvar k;
    generate
        for (k = 0; k < N_CUBE; k++) begin : g_cube
            pla_cube_match #(.N_IN(N_IN)) u_match (
                .en    (r_en[k]),
                .care  (r_care[k]),
                .val   (r_val[k]),
                .x     (x),
                .match (w_match[k])
            );
        end
    endgenerate

    // Index codes at or above N_CUBE match no entry, so such writes fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= '0;
            for (int i = 0; i < N_CUBE; i++) begin
                r_care[i] <= '0;
                r_val[i]  <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < N_CUBE; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    r_en[i]   <= cfg_en;
                    r_care[i] <= cfg_care;
                    r_val[i]  <= cfg_val;
                end
            end
        end
    end

    assign w_s2_hold = r_out_valid & ~out_ready;
    assign in_ready  = ~r_s1_valid | ~w_s2_hold;
    assign out_valid = r_out_valid;
    assign y         = r_y;

`ifdef PLA_MATCH_VEC_EN
    logic [N_CUBE-1:0] r_mv;
    assign match_vec = r_mv;
    always_comb begin
        first_idx = '0;
        for (int i = N_CUBE - 1; i >= 0; i--) first_idx = r_mv[i] ? IDX_W'(i) : first_idx;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_match  <= '0;
            r_out_valid <= 1'b0;
            r_y         <= 1'b0;
`ifdef PLA_MATCH_VEC_EN
            r_mv        <= '0;
`endif
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) r_s1_match <= w_match;
            end
            if (!w_s2_hold) begin
                r_out_valid <= r_s1_valid;
                r_y         <= |r_s1_match;
`ifdef PLA_MATCH_VEC_EN
                r_mv        <= r_s1_match;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pla_cube_sop_pipe.sv
// tb_pla_cube_sop_pipe: scoreboard bench for pla_cube_sop_pipe (N_IN=14, N_CUBE=8).
module tb_pla_cube_sop_pipe;

    localparam int NI = 14;
    localparam int NC = 8;
    localparam int IW = 3;

    logic          clk = 0;
    logic          rst_n = 1;
    logic          cfg_we = 0;
    logic [IW-1:0] cfg_idx = '0;
    logic [NI-1:0] cfg_care = '0;
    logic [NI-1:0] cfg_val = '0;
    logic          cfg_en = 0;
    logic          in_valid = 0;
    logic [NI-1:0] x = '0;
    logic          out_ready = 1;
    logic          in_ready;
    logic          out_valid;
    logic          y;
`ifdef PLA_MATCH_VEC_EN
    logic [NC-1:0] match_vec;
    logic [IW-1:0] first_idx;
`endif

    typedef struct {
        logic          y;
        logic [NC-1:0] mv;
        logic [IW-1:0] fi;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_out = 0;
    bit            lat_chk = 0;
    bit            stall_prev = 0;
    logic          y_prev = 0;
    logic          men   [NC];
    logic [NI-1:0] mcare [NC];
    logic [NI-1:0] mval  [NC];

    always #5 clk = ~clk;

    pla_cube_sop_pipe #(.N_IN(NI), .N_CUBE(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .cfg_en    (cfg_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PLA_MATCH_VEC_EN
        .match_vec (match_vec),
        .first_idx (first_idx),
`endif
        .y         (y)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [NI-1:0] v);
        exp_t e;
        e.mv  = '0;
        e.fi  = '0;
        e.cyc = cyc;
        for (int i = NC - 1; i >= 0; i--) begin
            e.mv[i] = men[i] && (((v ^ mval[i]) & mcare[i]) == '0);
            if (e.mv[i]) e.fi = IW'(i);
        end
        e.y = |e.mv;
        return e;
    endfunction

    // Handshakes are observed mid-cycle; they hold until the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            stall_prev = 0;
            for (int i = 0; i < NC; i++) begin
                men[i] = 0; mcare[i] = '0; mval[i] = '0;
            end
        end else begin
            if (stall_prev) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_y", y, y_prev);
            end
            if (out_valid && out_ready) begin
                chk("out_has_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_out++;
                    chk("y", y, e.y);
`ifdef PLA_MATCH_VEC_EN
                    chk("match_vec", match_vec, e.mv);
                    chk("first_idx", first_idx, e.fi);
`endif
                    if (lat_chk) chk("latency", cyc - e.cyc, 2);
                end
            end
            stall_prev = out_valid && !out_ready;
            y_prev = y;
            if (in_valid && in_ready) q.push_back(model(x));
            if (cfg_we && int'(cfg_idx) < NC) begin
                men[cfg_idx]   = cfg_en;
                mcare[cfg_idx] = cfg_care;
                mval[cfg_idx]  = cfg_val;
            end
        end
    end

    task automatic send(input logic [NI-1:0] v);
        bit acc = 0;
        int n = 0;
        in_valid = 1;
        x = v;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_accept", acc, 1);
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [NI-1:0] care,
                             input logic [NI-1:0] val, input logic en);
        cfg_we = 1; cfg_idx = idx; cfg_care = care; cfg_val = val; cfg_en = en;
        @(posedge clk);
        #1;
        cfg_we = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time %0t limit 200000", $time);
        $fatal(1);
    end

    initial begin
        logic [NI-1:0] vec [6];
        int base;
        vec[0] = 14'h3D25; vec[1] = 14'h0002; vec[2] = 14'h0001;
        vec[3] = 14'h3D24; vec[4] = 14'h1236; vec[5] = 14'h3FFE;
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        lat_chk = 1;
        for (int i = 0; i < 16; i++) send(NI'($urandom));
        in_valid = 0;
        drain(20);
        lat_chk = 0;
        chk("empty_table_count", n_out, 16);

        cfg_write(0, 14'h3FFF, 14'h3D25, 1);
        send(14'h3D25);
        send(14'h3D27);
        send(14'h3D24);
        in_valid = 0;
        drain(20);

        cfg_write(3, 14'h0003, 14'h0002, 1);
        send(14'h0002);
        send(14'h0001);
        send(14'h3D25);
        in_valid = 0;
        drain(20);

        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vec[i]);
                in_valid = 0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                repeat (4) @(negedge clk);
                chk("in_ready_full", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain(40);
        chk("stall_count", n_out - base, 6);

        in_valid = 1; x = 14'h3D25;
        cfg_we = 1; cfg_idx = 0; cfg_care = 14'h3FFF; cfg_val = 14'h3D25; cfg_en = 0;
        @(posedge clk);
        #1 cfg_we = 0;
        @(posedge clk);
        #1 in_valid = 0;
        drain(20);

        out_ready = 0;
        send(14'h0002);
        send(14'h0001);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        base = n_out;
        send(14'h3D25);
        in_valid = 0;
        drain(20);
        chk("post_rst_count", n_out - base, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
